inst_fetch_ctrl: RTL and testbench

Parametrised program-counter and fetch-control unit for the lab CPU; next generation of the single-program PC register. It supports multiple program entry points, signed relative branches, a hardware call/return stack, stall, and a halt/done handshake with the testbench. It sits between the control decoder/ALU flag and the instruction ROM address port.

---
 rtl/inst_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Program counter and fetch control: selectable entry points, relative/absolute
// branches, a register-based return stack, stall, and a halt/done handshake.
module inst_fetch_ctrl #(
  parameter int PC_W        = 10,
  parameter int OFF_W       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int NUM_PROGS   = 3,
  parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASE = {10'd256, 10'd128, 10'd0},
  localparam int SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  localparam int DEP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] ProgSel,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchAbs,
  input  logic             BranchRelEn,
  input  logic             ALU_flag,
  input  logic             Call,
  input  logic             Ret,
  input  logic [PC_W-1:0]  Target,
  input  logic [OFF_W-1:0] Offset,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             StackErr,
  output logic [DEP_W-1:0] Depth
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DEP_W-1:0]  depth_q, depth_d;
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];
  logic              push_en;
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic [PC_W-1:0]   ret_addr, off_ext, base_addr;

  // Out-of-range selectors fall back to program 0.
  always_comb begin
    base_addr = PROG_BASE[0 +: PC_W];
    for (int i = 1; i < NUM_PROGS; i++) begin
      if (ProgSel == SEL_W'(i)) base_addr = PROG_BASE[i*PC_W +: PC_W];
    end
  end

  assign off_ext  = PC_W'($signed(Offset));
  assign ret_addr = pc_q + PC_W'(1);
  assign push_idx = IDX_W'(depth_q);
  assign pop_idx  = IDX_W'(depth_q - DEP_W'(1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    push_en = 1'b0;
    // Start restarts from any state and loads the base on the same edge.
    if (Start) begin
      state_d = S_LOAD;
      pc_d    = base_addr;
      depth_d = '0;
    end else begin
      unique case (state_q)
        S_LOAD: state_d = S_RUN;
        S_RUN: begin
          if (Stall) begin
            state_d = S_RUN;
          end else if (Halt) begin
            state_d = S_DONE;
          end else if (Ret) begin
            if (depth_q == '0) begin
              state_d = S_ERR;
            end else begin
              pc_d    = stack_q[pop_idx];
              depth_d = depth_q - DEP_W'(1);
            end
          end else if (Call) begin
            if (depth_q == DEP_W'(STACK_DEPTH)) begin
              state_d = S_ERR;
            end else begin
              push_en = 1'b1;
              pc_d    = Target;
              depth_d = depth_q + DEP_W'(1);
            end
          end else if (BranchAbs) begin
            pc_d = Target;
          end else if (BranchRelEn && ALU_flag) begin
            pc_d = pc_q + off_ext;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
    end
  end

  // Entries survive pops and reloads; only the occupancy count is reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (push_en) begin
      stack_q[push_idx] <= ret_addr;
    end
  end

  assign ProgCtr  = pc_q;
  assign Depth    = depth_q;
  assign Running  = (state_q == S_RUN);
  assign Done     = (state_q == S_DONE);
  assign StackErr = (state_q == S_ERR);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: a queue-based reference model checked on
// every falling edge, plus hand-computed literal expectations along the way.
module tb_inst_fetch_ctrl;

  logic       Clk, Reset, Start, Stall, Halt, BranchAbs, BranchRelEn, ALU_flag, Call, Ret;
  logic [1:0] ProgSel;
  logic [9:0] Target;
  logic [7:0] Offset;
  logic [9:0] ProgCtr;
  logic       Running, Done, StackErr;
  logic [2:0] Depth;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
    .Halt(Halt), .BranchAbs(BranchAbs), .BranchRelEn(BranchRelEn), .ALU_flag(ALU_flag),
    .Call(Call), .Ret(Ret), .Target(Target), .Offset(Offset), .ProgCtr(ProgCtr),
    .Running(Running), .Done(Done), .StackErr(StackErr), .Depth(Depth)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: mode is one of "IDLE","LOAD","RUN","DONE","ERR".
  string       m_mode;
  int          m_pc;
  int          m_stk[$];
  int          bases[3] = '{0, 128, 256};

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_mode = "IDLE";
      m_pc   = 0;
      m_stk.delete();
    end else if (Start) begin
      m_mode = "LOAD";
      m_pc   = (ProgSel < 3) ? bases[ProgSel] : 0;
      m_stk.delete();
    end else if (m_mode == "LOAD") begin
      m_mode = "RUN";
    end else if (m_mode == "RUN" && !Stall) begin
      if (Halt) m_mode = "DONE";
      else if (Ret) begin
        if (m_stk.size() == 0) m_mode = "ERR";
        else m_pc = m_stk.pop_back();
      end else if (Call) begin
        if (m_stk.size() == 4) m_mode = "ERR";
        else begin
          m_stk.push_back((m_pc + 1) % 1024);
          m_pc = Target;
        end
      end else if (BranchAbs) m_pc = Target;
      else if (BranchRelEn && ALU_flag)
        m_pc = (m_pc + ((Offset >= 128) ? int'(Offset) - 256 : int'(Offset)) + 1024) % 1024;
      else m_pc = (m_pc + 1) % 1024;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    chk("model_pc",    ProgCtr,  m_pc);
    chk("model_depth", Depth,    m_stk.size());
    chk("model_run",   Running,  int'(m_mode == "RUN"));
    chk("model_done",  Done,     int'(m_mode == "DONE"));
    chk("model_err",   StackErr, int'(m_mode == "ERR"));
  end

  task automatic clr();
    Start = 0; ProgSel = 0; Stall = 0; Halt = 0; BranchAbs = 0; BranchRelEn = 0;
    ALU_flag = 0; Call = 0; Ret = 0; Target = 0; Offset = 0;
  endtask

  task automatic cyc(input string tag);
    @(posedge Clk);
    #1;
    $display("txn %-10s pc=%0d depth=%0d run=%0b done=%0b err=%0b", tag, ProgCtr, Depth, Running, Done, StackErr);
  endtask

  task automatic jump(input int t);
    clr(); BranchAbs = 1; Target = 10'(t); cyc("jump"); clr();
  endtask

  initial begin
    clr();
    Reset = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_pc", ProgCtr, 0); chk("rst_run", Running, 0); chk("rst_done", Done, 0);
    chk("rst_err", StackErr, 0); chk("rst_depth", Depth, 0);
    Reset = 1;
    cyc("idle");
    chk("idle_pc", ProgCtr, 0);

    Start = 1; ProgSel = 1; cyc("load1");
    chk("load_pc", ProgCtr, 128); chk("load_run", Running, 0);
    cyc("load2");
    Start = 0; cyc("run_enter");
    chk("run_pc", ProgCtr, 128); chk("run_flag", Running, 1);
    cyc("seq"); chk("seq1", ProgCtr, 129);
    cyc("seq"); chk("seq2", ProgCtr, 130);

    jump(20); chk("abs20", ProgCtr, 20);
    BranchRelEn = 1; ALU_flag = 1; Offset = 8'hF6; cyc("rel_taken");
    chk("rel_taken", ProgCtr, 10);
    jump(20);
    BranchRelEn = 1; ALU_flag = 0; Offset = 8'hF6; cyc("rel_not");
    chk("rel_not", ProgCtr, 21);
    jump(1023); cyc("wrap"); chk("wrap_up", ProgCtr, 0);
    jump(5);
    BranchRelEn = 1; ALU_flag = 1; Offset = 8'hF8; cyc("rel_wrap");
    chk("wrap_down", ProgCtr, 1021);

    jump(40);
    clr(); Call = 1; Target = 300; cyc("call");
    chk("call_pc", ProgCtr, 300); chk("call_depth", Depth, 1);
    clr(); cyc("seq");
    Ret = 1; cyc("ret");
    chk("ret_pc", ProgCtr, 41); chk("ret_depth", Depth, 0);
    clr(); Call = 1; Target = 500; cyc("call");
    Ret = 1; Call = 1; Target = 700; cyc("call_ret");
    chk("callret_pc", ProgCtr, 42); chk("callret_depth", Depth, 0);

    for (int i = 1; i <= 4; i++) begin
      clr(); Call = 1; Target = 10'(i * 100); cyc("nest");
    end
    chk("nest_depth", Depth, 4);
    clr(); Call = 1; Target = 600; cyc("overflow");
    chk("ovf_err", StackErr, 1); chk("ovf_pc", ProgCtr, 400); chk("ovf_run", Running, 0);
    clr(); BranchAbs = 1; Target = 5; Ret = 1; cyc("err_hold");
    chk("err_hold_pc", ProgCtr, 400); chk("err_hold_depth", Depth, 4);

    clr(); Start = 1; ProgSel = 0; cyc("reload");
    chk("reload_err", StackErr, 0); chk("reload_depth", Depth, 0);
    clr(); cyc("run_enter");
    jump(33);
    Ret = 1; cyc("underflow");
    chk("unf_err", StackErr, 1); chk("unf_pc", ProgCtr, 33);
    clr(); Start = 1; ProgSel = 3; cyc("sel_oob");
    chk("sel_oob_pc", ProgCtr, 0); chk("sel_oob_err", StackErr, 0);
    clr(); cyc("run_enter");
    cyc("seq"); chk("pre_stall", ProgCtr, 1);
    for (int i = 0; i < 3; i++) begin
      clr(); Stall = 1; BranchAbs = 1; Halt = 1; Target = 900; cyc("stall");
      chk("stall_pc", ProgCtr, 1);
    end
    clr(); Halt = 1; cyc("halt");
    chk("halt_done", Done, 1); chk("halt_pc", ProgCtr, 1);
    clr(); BranchAbs = 1; Target = 900; cyc("done_hold");
    chk("done_hold_pc", ProgCtr, 1);
    clr(); Start = 1; ProgSel = 2; cyc("load_p2");
    chk("p2_pc", ProgCtr, 256); chk("p2_done", Done, 0);
    clr(); cyc("run_enter");

    jump(70);
    Call = 1; Target = 10; cyc("call");
    clr(); Call = 1; Target = 76; cyc("call");
    clr(); cyc("seq");
    chk("pre_rst_pc", ProgCtr, 77); chk("pre_rst_depth", Depth, 2);
    #3 Reset = 0;
    #1;
    $display("txn %-10s pc=%0d depth=%0d run=%0b", "async_rst", ProgCtr, Depth, Running);
    chk("arst_pc", ProgCtr, 0); chk("arst_depth", Depth, 0); chk("arst_run", Running, 0);
    cyc("rst_hold");
    Reset = 1;
    Start = 1; ProgSel = 1; cyc("load1");
    clr(); cyc("run_enter");
    cyc("seq"); chk("post_rst_pc", ProgCtr, 129);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
